multicycle_decoder: RTL
=======================

MULTICYCLE_DECODER -- requirements
Module: multicycle_decoder

Interface
REQ-001 Parameter ALU_CTRL_W, default 3, sets the ALUControl width; legal values are 3 or greater.
REQ-002 Parameter CNT_W, default 32, sets the width of the retired-instruction counter.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 Op, Funct, Rd  input  2/6/4  instruction fields from the instruction register.
REQ-006 mem_ready  input  1  memory done strobe for the current access.
REQ-007 mem_req  output  1  memory access request.
REQ-008 IRWrite, NextPC, AdrSrc, ALUSrcA, RegW, MemW, Branch, PCS, NoWrite  output  1 each  datapath strobes and selects.
REQ-009 ALUSrcB, ResultSrc, ImmSrc, RegSrc, FlagW  output  2 each  datapath selects and flag-write enables.
REQ-010 ALUControl  output  ALU_CTRL_W  ALU operation code.
REQ-011 illegal  output  1  one-cycle pulse for an unsupported instruction.
REQ-012 state_o  output  4  current FSM state, for debug.
REQ-013 retired  output  CNT_W  count of completed instructions.

Function
REQ-014 The FSM SHALL have these states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
REQ-015 FETCH transitions:
- mem_req=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
- Holds while mem_ready=0.
- In the cycle mem_ready=1: IRWrite=1 and NextPC=1, then moves to DECODE.
REQ-016 DECODE outputs: ALUSrcA=1, ALUSrcB=10, ResultSrc=10.
REQ-017 DECODE next state:
- Op=01 goes to MEMADR.
- Op=10 goes to BRANCH.
- Op=00 with Funct[5]=1 goes to EXECI.
- Op=00 with Funct[5]=0 goes to EXECR.
- Op=11, or Op=00 with an unsupported cmd, raises illegal for one cycle and goes to FETCH.
REQ-018 MEMADR: ALUSrcA=0, ALUSrcB=01; next state is MEMRD if Funct[0]=1, otherwise MEMWR.
REQ-019 MEMRD: mem_req=1, AdrSrc=1; holds until mem_ready=1, then goes to MEMWB.
REQ-020 MEMWB: ResultSrc=01, RegW=1; next state is FETCH.
REQ-021 MEMWR: mem_req=1, AdrSrc=1, MemW=1; holds until mem_ready=1, then goes to FETCH.
REQ-022 EXECR and EXECI:
- ALUSrcA=0; ALUSrcB=00 in EXECR, 01 in EXECI.
- ALU decode is active.
- Next state is ALUWB.
REQ-023 ALUWB: ResultSrc=00; RegW=~NoWrite; next state is FETCH.
REQ-024 BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1; next state is FETCH.
REQ-025 Any output not listed for a state SHALL be 0 in that state.
REQ-026 ImmSrc and RegSrc SHALL be decoded combinationally from Op in every state:
- Op=00: ImmSrc=00, RegSrc=00.
- Op=01: ImmSrc=01, RegSrc=10.
- Op=10: ImmSrc=10, RegSrc=x1.
REQ-027 ALU decode on cmd=Funct[4:1]:
- ADD 0100 gives code 0.
- SUB 0010 gives code 1.
- AND 0000 gives code 2.
- ORR 1100 gives code 3.
- EOR 0001 gives code 4.
- CMP 1010 gives code 1 with NoWrite=1.
- Codes are zero-extended to ALU_CTRL_W.
REQ-028 When ALU decode is inactive, ALUControl SHALL be 0 (ADD), FlagW SHALL be 00, and NoWrite SHALL be 0.
REQ-029 FlagW rules:
- FlagW[1] = S, where S = Funct[0].
- FlagW[0] = S AND (code 0 or code 1).
- CMP with S=0 is unsupported.
REQ-030 PCS = (Rd=1111 AND RegW) OR Branch.
REQ-031 retired SHALL increment by 1, wrapping modulo 2^CNT_W, on every transition into FETCH from MEMWB, MEMWR, ALUWB or BRANCH; an illegal exit does not count.
REQ-032 If mem_ready is asserted outside FETCH, MEMRD or MEMWR, it SHALL be ignored.

Reset
REQ-033 While reset=0 (asynchronous):
- state is FETCH and retired is 0.
- All strobes are 0, including IRWrite, NextPC, RegW, MemW and illegal.
- mem_req is forced to 0.
REQ-034 Reset asserted mid-access SHALL abort the access with no further MemW or RegW.
REQ-035 After reset deasserts, the first cycle SHALL be a FETCH request.

Structure
REQ-036 Package arm_ctrl_pkg SHALL hold the state enum (4-bit) and the ALU code localparams.
REQ-037 Combinational ALU decode SHALL live in a sub-module alu_decoder; the FSM, counter and output decode stay in multicycle_decoder.

Verification
REQ-038 ADD R1,R2,R3 (Op=00, Funct=001000), mem_ready=1 → states 0,1,6,8,0; RegW=1 only in ALUWB; retired=1.
REQ-039 LDR (Op=01, Funct=011001), mem_ready held low 3 cycles in MEMRD → MEMRD is held 4 cycles; RegW=1 in MEMWB only; state sequence 0,1,2,3,3,3,3,4,0.
REQ-040 CMP with S=1 (Funct=010101) → ALUControl=001, FlagW=11, RegW=0 in ALUWB; retired increments.
REQ-041 Op=11 → illegal pulses 1 cycle in DECODE, next state FETCH, retired unchanged.
REQ-042 Reset asserted during MEMWR with mem_ready=0 → state 0 immediately, MemW=0, retired=0.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared types for the multicycle ARM control unit: FSM state encoding and ALU operation codes.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_ORR = 3'd3;
  localparam logic [2:0] ALU_EOR = 3'd4;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decode of Funct[4:1]/S; outputs forced to ADD/no-flags when inactive.
// supported is reported regardless of active so DECODE can flag illegal data-processing ops.
module alu_decoder
  import arm_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  logic [5:0]            funct,
  input  logic                  active,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic [1:0]            flagw,
  output logic                  nowrite,
  output logic                  supported
);

  logic [3:0] cmd;
  logic       s;
  logic [2:0] code;
  logic       nw;

  assign cmd = funct[4:1];
  assign s   = funct[0];

  always_comb begin
    code      = ALU_ADD;
    nw        = 1'b0;
    supported = 1'b1;
    case (cmd)
      4'b0100: code = ALU_ADD;
      4'b0010: code = ALU_SUB;
      4'b0000: code = ALU_AND;
      4'b1100: code = ALU_ORR;
      4'b0001: code = ALU_EOR;
      // CMP only makes sense when it sets flags
      4'b1010: begin
        code      = ALU_SUB;
        nw        = 1'b1;
        supported = s;
      end
      default: supported = 1'b0;
    endcase
  end

  assign alu_ctrl = active ? ALU_CTRL_W'(code) : '0;
  assign flagw    = active ? {s, s & ((code == ALU_ADD) || (code == ALU_SUB))} : 2'b00;
  assign nowrite  = active & nw;

endmodule

// File: rtl/multicycle_decoder.sv
// Multicycle ARM control FSM: per-state datapath strobes, waits on mem_ready for memory states.
// Counts retired instructions; reset aborts any access and masks all strobes combinationally.
module multicycle_decoder
  import arm_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            Op,
  input  logic [5:0]            Funct,
  input  logic [3:0]            Rd,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  IRWrite,
  output logic                  NextPC,
  output logic                  AdrSrc,
  output logic                  ALUSrcA,
  output logic                  RegW,
  output logic                  MemW,
  output logic                  Branch,
  output logic                  PCS,
  output logic                  NoWrite,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ImmSrc,
  output logic [1:0]            RegSrc,
  output logic [1:0]            FlagW,
  output logic [ALU_CTRL_W-1:0] ALUControl,
  output logic                  illegal,
  output logic [3:0]            state_o,
  output logic [CNT_W-1:0]      retired
);

  state_t state, state_nxt;
  logic   alu_active;
  logic   supported;
  logic   nowrite_q;
  logic   retire;

  alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_decoder (
    .funct    (Funct),
    .active   (alu_active),
    .alu_ctrl (ALUControl),
    .flagw    (FlagW),
    .nowrite  (NoWrite),
    .supported(supported)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // NoWrite is only live during EXEC, but ALUWB needs it to suppress the write-back
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired   <= '0;
      nowrite_q <= 1'b0;
    end else begin
      if (retire) retired <= retired + CNT_W'(1);
      if (alu_active) nowrite_q <= NoWrite;
    end
  end

  always_comb begin
    state_nxt  = state;
    retire     = 1'b0;
    alu_active = 1'b0;
    mem_req    = 1'b0;
    IRWrite    = 1'b0;
    NextPC     = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    RegW       = 1'b0;
    MemW       = 1'b0;
    Branch     = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    illegal    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (mem_ready) begin
          IRWrite   = 1'b1;
          NextPC    = 1'b1;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        case (Op)
          2'b01: state_nxt = S_MEMADR;
          2'b10: state_nxt = S_BRANCH;
          2'b00: begin
            if (!supported) begin
              illegal   = 1'b1;
              state_nxt = S_FETCH;
            end else begin
              state_nxt = Funct[5] ? S_EXECI : S_EXECR;
            end
          end
          default: begin
            illegal   = 1'b1;
            state_nxt = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcB   = 2'b01;
        state_nxt = Funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegW      = 1'b1;
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        MemW    = 1'b1;
        if (mem_ready) begin
          state_nxt = S_FETCH;
          retire    = 1'b1;
        end
      end
      S_EXECR: begin
        alu_active = 1'b1;
        state_nxt  = S_ALUWB;
      end
      S_EXECI: begin
        alu_active = 1'b1;
        ALUSrcB    = 2'b01;
        state_nxt  = S_ALUWB;
      end
      S_ALUWB: begin
        RegW      = ~nowrite_q;
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        Branch    = 1'b1;
        state_nxt = S_FETCH;
        retire    = 1'b1;
      end
      default: state_nxt = S_FETCH;
    endcase
    // Reset parks the FSM in FETCH, so the request and its strobes must be masked
    if (!reset) begin
      mem_req = 1'b0;
      IRWrite = 1'b0;
      NextPC  = 1'b0;
      RegW    = 1'b0;
      MemW    = 1'b0;
      Branch  = 1'b0;
      illegal = 1'b0;
    end
  end

  assign PCS = ((Rd == 4'hF) && RegW) || Branch;

  always_comb begin
    ImmSrc = 2'b00;
    RegSrc = 2'b00;
    case (Op)
      2'b01: begin ImmSrc = 2'b01; RegSrc = 2'b10; end
      2'b10: begin ImmSrc = 2'b10; RegSrc = 2'b01; end
      default: ;
    endcase
  end

  assign state_o = state;

endmodule
